// File: rtl/ste_stream_sequencer_if.sv
// Byte-stream handshake bundle feeding the STE stream sequencer.
// The master drives bytes and the slave accepts them with in_ready.
interface ste_stream_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/ste_stream_sequencer.sv
// Packs bytes into 16-bit symbols, steps an STE array once per symbol and queues report offsets.
// Optional macro STE_SEQ_OVERFLOW_DROP_EN: drop reports on a full FIFO instead of stalling.
module ste_stream_sequencer #(
  parameter int OFS_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  ste_stream_sequencer_if.slave inBus,
  output logic [15:0]          sym_out,
  output logic                 step_en,
  output logic                 array_clear,
  input  logic                 array_report,
  output logic [OFS_W-1:0]     rpt_offset,
  output logic                 rpt_valid,
  input  logic                 rpt_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 odd_byte
`ifdef STE_SEQ_OVERFLOW_DROP_EN
  ,
  output logic                 rpt_dropped
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_HI = 3'd1,
    FETCH_LO = 3'd2,
    STEP     = 3'd3,
    DONE     = 3'd4
  } stateT;

  stateT            stateR;
  stateT            stateNext;
  logic [15:0]      symR;
  logic [OFS_W-1:0] offsetR;
  logic             lastPendingR;
  logic             doneR;
  logic             oddR;
  logic             busyR;
  logic             inReadyR;
  logic [OFS_W-1:0] fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtrR;
  logic [PTR_W-1:0] rdPtrR;
  logic [PTR_W:0]   countR;
  logic             fifoFull;
  logic             popS;
  logic             pushS;
  logic             stallS;
  logic             dropS;
  logic             handshakeS;

  assign rpt_valid   = (countR != (PTR_W+1)'(0));
  assign fifoFull    = (countR == (PTR_W+1)'(FIFO_DEPTH));
  assign popS        = rpt_valid && rpt_ready;
  assign rpt_offset  = rpt_valid ? fifoMem[rdPtrR] : OFS_W'(0);
  assign handshakeS  = inBus.in_valid && inReadyR;
  assign inBus.in_ready = inReadyR;
  assign sym_out     = symR;
  assign busy        = busyR;
  assign done        = doneR;
  assign odd_byte    = oddR;

  // A report that cannot be stored either holds the step or is discarded
`ifdef STE_SEQ_OVERFLOW_DROP_EN
  assign stallS = 1'b0;
  assign dropS  = array_report && fifoFull && !popS;
`else
  assign stallS = array_report && fifoFull && !popS;
  assign dropS  = 1'b0;
`endif

  // Next-state decode plus the single-cycle array strobes and FIFO push
  always_comb begin
    stateNext   = stateR;
    step_en     = 1'b0;
    array_clear = 1'b0;
    pushS       = 1'b0;
    case (stateR)
      IDLE, DONE: begin
        if (start) begin
          array_clear = 1'b1;
          stateNext   = FETCH_HI;
        end else begin
          stateNext = stateR;
        end
      end
      FETCH_HI: begin
        if (handshakeS) begin
          stateNext = inBus.in_last ? DONE : FETCH_LO;
        end else begin
          stateNext = FETCH_HI;
        end
      end
      FETCH_LO: begin
        if (handshakeS) begin
          stateNext = STEP;
        end else begin
          stateNext = FETCH_LO;
        end
      end
      STEP: begin
        if (stallS) begin
          stateNext = STEP;
        end else begin
          step_en   = 1'b1;
          pushS     = array_report && (!fifoFull || popS);
          stateNext = lastPendingR ? DONE : FETCH_HI;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State register with registered status flags derived from the next state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stateR   <= IDLE;
      busyR    <= 1'b0;
      inReadyR <= 1'b0;
      doneR    <= 1'b0;
    end else begin
      stateR   <= stateNext;
      busyR    <= (stateNext == FETCH_HI) || (stateNext == FETCH_LO) || (stateNext == STEP);
      inReadyR <= (stateNext == FETCH_HI) || (stateNext == FETCH_LO);
      doneR    <= (stateNext == DONE);
    end
  end

  // Symbol assembly, offset counter and scan flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      symR         <= 16'h0000;
      offsetR      <= OFS_W'(0);
      lastPendingR <= 1'b0;
      oddR         <= 1'b0;
    end else begin
      case (stateR)
        IDLE, DONE: begin
          if (start) begin
            offsetR <= OFS_W'(0);
            oddR    <= 1'b0;
          end
        end
        FETCH_HI: begin
          if (handshakeS) begin
            symR[15:8] <= inBus.in_data;
            oddR       <= inBus.in_last;
          end
        end
        FETCH_LO: begin
          if (handshakeS) begin
            symR[7:0]    <= inBus.in_data;
            lastPendingR <= inBus.in_last;
          end
        end
        STEP: begin
          if (!stallS) begin
            offsetR <= offsetR + OFS_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef STE_SEQ_OVERFLOW_DROP_EN
  logic droppedR;
  assign rpt_dropped = droppedR;

  // Sticky flag for reports lost to a full FIFO
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      droppedR <= 1'b0;
    end else if (((stateR == IDLE) || (stateR == DONE)) && start) begin
      droppedR <= 1'b0;
    end else if ((stateR == STEP) && dropS) begin
      droppedR <= 1'b1;
    end
  end
`endif

  // First-word-fall-through report FIFO; survives start, cleared only by reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtrR <= PTR_W'(0);
      rdPtrR <= PTR_W'(0);
      countR <= (PTR_W+1)'(0);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifoMem[i] <= OFS_W'(0);
      end
    end else begin
      if (pushS) begin
        fifoMem[wrPtrR] <= offsetR;
        wrPtrR          <= wrPtrR + PTR_W'(1);
      end
      if (popS) begin
        rdPtrR <= rdPtrR + PTR_W'(1);
      end
      countR <= countR + (PTR_W+1)'(pushS) - (PTR_W+1)'(popS);
    end
  end

endmodule

// File: tb/tb_ste_stream_sequencer.sv
// Scoreboard bench: directed byte streams push expected symbols/offsets; a monitor checks steps and pops.
module tb_ste_stream_sequencer;
  localparam int OFS_W = 3;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [15:0]      sym_out;
  logic             step_en;
  logic             array_clear;
  logic             array_report;
  logic [OFS_W-1:0] rpt_offset;
  logic             rpt_valid;
  logic             rpt_ready = 1'b0;
  logic             busy;
  logic             done;
  logic             odd_byte;
  logic             rptAll = 1'b0;
`ifdef STE_SEQ_OVERFLOW_DROP_EN
  logic             rpt_dropped;
`endif

  int total = 0;
  int bad = 0;
  logic [15:0]      symQ[$];
  logic [OFS_W-1:0] ofsQ[$];

  ste_stream_sequencer_if bus();

  ste_stream_sequencer #(.OFS_W(OFS_W), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .inBus(bus),
    .sym_out(sym_out), .step_en(step_en), .array_clear(array_clear),
    .array_report(array_report), .rpt_offset(rpt_offset), .rpt_valid(rpt_valid),
    .rpt_ready(rpt_ready), .busy(busy), .done(done), .odd_byte(odd_byte)
`ifdef STE_SEQ_OVERFLOW_DROP_EN
    , .rpt_dropped(rpt_dropped)
`endif
  );

  // Array model: reports on every symbol or only on "CC"
  assign array_report = rptAll | (sym_out == 16'h4343);

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every step and every pop is compared with the scoreboard head
  always @(negedge clock) begin
    if (reset_n && step_en) begin
      if (symQ.size() == 0) check("unexpected_step", {16'h0, sym_out}, 32'hFFFF_FFFF);
      else check("step_sym", {16'h0, sym_out}, {16'h0, symQ.pop_front()});
    end
    if (reset_n && rpt_valid && rpt_ready) begin
      if (ofsQ.size() == 0) check("unexpected_pop", {29'h0, rpt_offset}, 32'hFFFF_FFFF);
      else check("rpt_offset", {29'h0, rpt_offset}, {29'h0, ofsQ.pop_front()});
    end
  end

  task automatic pushByte(input logic [7:0] d, input logic l);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!bus.in_ready) check("byte_timeout", 32'h0, 32'h1);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic startPulse(input logic expClear);
    @(posedge clock);
    #1 start = 1'b1;
    @(negedge clock);
    check("array_clear", {31'h0, array_clear}, {31'h0, expClear});
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("done_seen", {31'h0, done}, 32'h1);
  endtask

  task automatic waitStall(input logic [15:0] expSym);
    int n = 0;
    @(negedge clock);
    while (!(busy && !bus.in_ready && !step_en) && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("stall_seen", {31'h0, busy && !bus.in_ready && !step_en}, 32'h1);
    check("stall_sym", {16'h0, sym_out}, {16'h0, expSym});
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_sym", {16'h0, sym_out}, 32'h0);
    check("rst_flags", {25'h0, step_en, array_clear, bus.in_ready, busy, done, odd_byte, rpt_valid}, 32'h0);
    check("rst_ofs", {29'h0, rpt_offset}, 32'h0);
    reset_n = 1'b1;

    // Reset mid FETCH_LO
    startPulse(1'b1);
    pushByte(8'h41, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_sym", {16'h0, sym_out}, 32'h0);
    check("midrst_flags", {27'h0, step_en, bus.in_ready, busy, done, rpt_valid}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Basic scan: reports only on 4343 (offset 1)
    rpt_ready = 1'b1;
    symQ.push_back(16'h4141); symQ.push_back(16'h4343); symQ.push_back(16'h4341);
    ofsQ.push_back(3'd1);
    startPulse(1'b1);
    @(negedge clock);
    check("clear_onecycle", {31'h0, array_clear}, 32'h0);
    pushByte(8'h41, 1'b0); pushByte(8'h41, 1'b0);
    pushByte(8'h43, 1'b0); pushByte(8'h43, 1'b0);
    pushByte(8'h43, 1'b0); pushByte(8'h41, 1'b1);
    waitDone();
    check("basic_odd", {31'h0, odd_byte}, 32'h0);
    check("basic_busy", {31'h0, busy}, 32'h0);

    // Odd stream: trailing hi byte discarded
    symQ.push_back(16'h4141);
    startPulse(1'b1);
    pushByte(8'h41, 1'b0); pushByte(8'h41, 1'b0); pushByte(8'h43, 1'b1);
    waitDone();
    check("odd_flag", {31'h0, odd_byte}, 32'h1);
    check("odd_inready", {31'h0, bus.in_ready}, 32'h0);

    // Backpressure: FIFO fills with 0..3, symbol 0505 stalls
    rpt_ready = 1'b0;
    rptAll = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      symQ.push_back({i[7:0], i[7:0]});
      ofsQ.push_back(OFS_W'(i - 1));
    end
    startPulse(1'b1);
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          pushByte(i[7:0], 1'b0);
          pushByte(i[7:0], i == 6);
        end
      end
      begin
        waitStall(16'h0505);
        check("bp_head", {29'h0, rpt_offset}, 32'h0);
        repeat (3) @(negedge clock);
        check("bp_hold_step", {31'h0, step_en}, 32'h0);
        check("bp_hold_sym", {16'h0, sym_out}, 32'h0505);
        @(posedge clock);
        #1 rpt_ready = 1'b1;
        @(negedge clock);
        check("bp_release_step", {31'h0, step_en}, 32'h1);
        @(posedge clock);
        #1 rpt_ready = 1'b0;
        waitStall(16'h0606);
        @(posedge clock);
        #1 rpt_ready = 1'b1;
      end
    join
    waitDone();
    repeat (8) @(negedge clock);
    check("bp_drained", {31'h0, rpt_valid}, 32'h0);

    // Offset wrap with OFS_W=3; a start while fetching is ignored
    for (int i = 0; i < 10; i++) begin
      symQ.push_back({8'h10 + i[7:0], 8'h10 + i[7:0]});
      ofsQ.push_back(OFS_W'(i));
    end
    startPulse(1'b1);
    startPulse(1'b0);
    check("ignored_start_state", {31'h0, bus.in_ready}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      pushByte(8'h10 + i[7:0], 1'b0);
      pushByte(8'h10 + i[7:0], i == 9);
    end
    waitDone();

    // Restart: done drops, offset restarts at 0
    rptAll = 1'b0;
    symQ.push_back(16'h4343);
    ofsQ.push_back(3'd0);
    startPulse(1'b1);
    check("restart_done", {31'h0, done}, 32'h0);
    pushByte(8'h43, 1'b0); pushByte(8'h43, 1'b1);
    waitDone();
    repeat (5) @(negedge clock);
    check("sym_queue_empty", symQ.size(), 32'h0);
    check("ofs_queue_empty", ofsQ.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/ste_stream_sequencer.md
Name: ste_stream_sequencer

Overview:
- Sequences a state-transition-element (STE) automaton array over a byte stream.
- Packs incoming bytes into 16-bit symbols, first byte in [15:8], and presents one symbol per step.
- Pulses the array's step enable and captures the array's combinational report into a report-offset FIFO.
- Sits between the input byte source and the STE array; the array's activation flip-flops use step_en as their clock enable.

Parameters:
- OFS_W, 32, width of symbol offset counter and report records
- FIFO_DEPTH, 4, report FIFO entries (power of two, >=2)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a new scan
- in_data  in  8  input byte
- in_valid  in  1  byte valid
- in_last  in  1  byte is final byte of stream
- in_ready  out  1  sequencer accepts byte
- sym_out  out  16  symbol to STE array, {hi byte, lo byte}
- step_en  out  1  array flip-flops capture next-active state this edge
- array_clear  out  1  one-cycle pulse; array clears all activation flip-flops
- array_report  in  1  OR of reporting STE outputs for current sym_out (combinational)
- rpt_offset  out  OFS_W  symbol index of head report
- rpt_valid  out  1  FIFO non-empty
- rpt_ready  in  1  consumer pops head
- busy  out  1  state not IDLE/DONE
- done  out  1  scan finished, held until next start
- odd_byte  out  1  stream ended on hi byte; trailing byte discarded

Behaviour:
- Reset (async, reset_n=0): state IDLE; sym_out=0; step_en, array_clear, in_ready, busy, done, odd_byte = 0; offset=0; FIFO empty (rpt_valid=0, rpt_offset=0).
- States: IDLE, FETCH_HI, FETCH_LO, STEP, DONE.
- IDLE/DONE + start: offset<=0, done<=0, odd_byte<=0, array_clear=1 for that cycle, next FETCH_HI. FIFO is not flushed. start in any other state is ignored.
- FETCH_HI: in_ready=1. On handshake: sym_out[15:8]<=in_data.
  - If in_last: odd_byte<=1, next DONE.
  - Else: next FETCH_LO.
- FETCH_LO: in_ready=1. On handshake: sym_out[7:0]<=in_data, last_pending<=in_last, next STEP.
- STEP: in_ready=0; sym_out stable; evaluated every cycle in STEP.
  - Stall condition: array_report=1 AND FIFO full AND no pop this cycle. Then step_en=0, stay in STEP; array state and sym_out are unchanged, so the report re-evaluates identically.
  - Otherwise: step_en=1 for exactly this cycle.
  - If array_report=1: push current offset.
  - offset<=offset+1, wrapping modulo 2^OFS_W.
  - Next state: DONE if last_pending, else FETCH_HI.
- Throughput: 3 cycles per symbol minimum with in_valid held high.
- Latency: report pushed at the step edge; rpt_valid rises the cycle after.
- DONE: done=1, busy=0; sym_out holds last symbol; step_en=0.
- FIFO rules:
  - First-word-fall-through; rpt_offset = head entry.
  - Pop on rpt_valid&&rpt_ready.
  - Simultaneous push and pop when full is legal: count unchanged, no stall.
  - Pop when empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-scan aborts immediately to reset values. In-flight bytes are lost; the source must restart the stream.
- in_data is ignored whenever in_ready=0.

Optional Feature:
- Macro: STE_SEQ_OVERFLOW_DROP_EN.
- Defined: STEP never stalls. A report arriving with FIFO full and no pop is dropped, and sticky output rpt_dropped (1 bit, port present only when defined) is set. rpt_dropped clears on start or reset. step_en fires every STEP cycle.
- Undefined: stall behaviour as specified above. No rpt_dropped port.

Test Plan:
- Reset: assert reset_n=0 mid-FETCH_LO -> all outputs zero asynchronously, state IDLE, rpt_valid=0.
- Basic scan: start, bytes 41 41 43 43 43 41 (last on 41), bench report=1 only when sym_out==16'h4343 -> step_en pulses 3 times with sym_out 4141, 4343, 4341. One FIFO entry, rpt_offset=1. done=1, odd_byte=0.
- Odd stream: bytes 41 41 43 (last on 43) -> one step (4141), then done=1, odd_byte=1. No second step; in_ready=0 after.
- Backpressure: FIFO_DEPTH=4, rpt_ready=0, report=1 on every symbol, 6 symbols -> offsets 0..3 stored. STEP stalls on symbol 4 with step_en=0 and sym_out held. Raising rpt_ready for 1 cycle pops 0 and steps symbol 4 the same cycle.
- Wrap: OFS_W=3, 10 symbols all reporting, rpt_ready=1 -> rpt_offset sequence 0..7,0,1.
- Restart: start during FETCH_HI ignored. After done, start -> array_clear pulses once, offset restarts at 0, done drops the same cycle.
